// File: rtl/inv_affine_input_serial.sv
// Byte-serial AES inverse affine input stage: accepts a word, transforms one byte
// per clock (LSB first), then holds the finished word on a valid/ready output.
module inv_affine_input_serial #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_data,
   input  logic                  in_dec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_data,
   output logic                  busy
);

   localparam int W  = 8 * NBYTES;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_next;
   logic [W-1:0]  shreg;
   logic [W-1:0]  shifted;
   logic [CW-1:0] cnt;
   logic          mode;
   logic [7:0]    byte_f;

   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   endfunction

   assign byte_f = mode ? inv_affine(shreg[7:0]) : shreg[7:0];

   // The transformed low byte enters at the top so the word rotates back into
   // its original byte order after NBYTES shifts.
   generate
      if (NBYTES == 1) begin : g_single
         assign shifted = byte_f;
      end else begin : g_multi
         assign shifted = {byte_f, shreg[W-1:8]};
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == LAST) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
         mode  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg <= in_data;
                  mode  <= in_dec;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               shreg <= shifted;
               cnt   <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_data = shreg;

endmodule

// File: tb/tb_inv_affine_input_serial.sv
// Scoreboard bench for inv_affine_input_serial: directed cases plus 100 random
// words, checked against a bit-equation model of the inverse affine byte map.
module tb_inv_affine_input_serial;

   localparam int N = 4;
   localparam int W = 8 * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_dec = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int n_in  = 0;
   int n_out = 0;
   logic [W-1:0] exp_q[$];

   inv_affine_input_serial #(.NBYTES(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dec(in_dec),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // b[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] ^ c[i], c = 8'h05
   function automatic logic [7:0] ref_byte(input logic [7:0] x, input logic dec);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h05;
      if (!dec) return x;
      for (int i = 0; i < 8; i++)
         b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ c[i];
      return b;
   endfunction

   function automatic logic [W-1:0] ref_word(input logic [W-1:0] x, input logic dec);
      logic [W-1:0] y;
      for (int k = 0; k < N; k++)
         y[8*k +: 8] = ref_byte(x[8*k +: 8], dec);
      return y;
   endfunction

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %h with empty scoreboard at %0t", out_data, $time);
         end else begin
            check("out_word", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic dec);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_dec   = dec;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ref_word(d, dec));
            n_in++;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready never seen, got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called the cycle after acceptance; lat counts cycles from the handshake cycle.
   task automatic wait_out(output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      for (int i = 1; i < 60; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int  lat, bcnt;
   bit  stim_done;

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      tick();

      // Inverse transform with known-answer word
      out_ready = 1'b1;
      send(32'h7C63ED05, 1'b1);
      wait_out(lat, bcnt);
      check("dec_latency", 64'(lat), 64'(N + 1));
      check("dec_busy_cycles", 64'(bcnt), 64'(N));
      check("dec_kat", 64'(out_data), 64'h0100CA66);
      tick();

      // Pass-through
      send(32'h7C63ED05, 1'b0);
      wait_out(lat, bcnt);
      check("pass_latency", 64'(lat), 64'(N + 1));
      check("pass_data", 64'(out_data), 64'h7C63ED05);
      tick();

      // Backpressure with an ignored input word during the stall
      out_ready = 1'b0;
      send(32'h7C63ED05, 1'b1);
      wait_out(lat, bcnt);
      check("bp_latency", 64'(lat), 64'(N + 1));
      in_valid = 1'b1;
      in_data  = 32'hFFFFFFFF;
      in_dec   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         check("bp_hold_data", 64'(out_data), 64'h0100CA66);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      check("bp_single_handshake", 64'(n_out), 64'(n_in));
      tick();

      // Reset during the second BUSY cycle aborts the word
      send(32'h7C63ED05, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      n_in--;
      @(negedge clk);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_out_data", 64'(out_data), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_valid", 64'(out_valid), 64'd0);
      end
      tick();
      send(32'h00000063, 1'b1);
      wait_out(lat, bcnt);
      check("post_abort_data", 64'(out_data), 64'(ref_word(32'h00000063, 1'b1)));
      tick();

      // Random words with random idle gaps and random downstream stalls
      stim_done = 1'b0;
      fork
         begin
            for (int w = 0; w < 100; w++) begin
               send($urandom, 1'($urandom_range(0, 1)));
               repeat ($urandom_range(0, 2)) tick();
            end
            for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               tick();
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      repeat (3) tick();
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
      check("rand_word_count", 64'(n_out), 64'(n_in));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
